// File: rtl/store_sequencer.sv
// Store sequencer: drives sw straight to a write cycle and sh/sb through read-modify-write.
// Optional alignment fault detection is enabled by defining STORE_SEQ_ALIGN_CHECK_EN.
module store_sequencer #(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  store_type,
    input  logic [31:0] addr_in,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mdr_load,
    output logic [1:0]  ss_control,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic        misalign
);

    typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             fault;

`ifdef STORE_SEQ_ALIGN_CHECK_EN
    // Only plain sh (01) checks the halfword bit; 11 decodes as sb and never faults.
    assign fault = ((store_type == 2'b00) && (addr_in[1:0] != 2'b00)) ||
                   ((store_type == 2'b01) && addr_in[0]);
`else
    assign fault = 1'b0;
`endif

    // Strobes default low each cycle and are set on the transition into their state,
    // so every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_addr   <= '0;
            ss_control <= 2'b00;
            mem_rd     <= 1'b0;
            mdr_load   <= 1'b0;
            mem_wr     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            misalign   <= 1'b0;
        end else begin
            mem_rd   <= 1'b0;
            mdr_load <= 1'b0;
            mem_wr   <= 1'b0;
            done     <= 1'b0;
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr   <= addr_in;
                        ss_control <= store_type;
                        busy       <= 1'b1;
                        if (fault) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            misalign <= 1'b1;
                        end else if (store_type == 2'b00) begin
                            state  <= WRITE;
                            mem_wr <= 1'b1;
                        end else begin
                            state  <= READ;
                            mem_rd <= 1'b1;
                            cnt    <= CNT_INIT;
                        end
                    end
                end
                READ: begin
                    if (cnt != '0) begin
                        cnt    <= cnt - 1'b1;
                        mem_rd <= 1'b1;
                    end else begin
                        state    <= LATCH;
                        mdr_load <= 1'b1;
                    end
                end
                LATCH: begin
                    state  <= WRITE;
                    mem_wr <= 1'b1;
                end
                WRITE: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    ss_control <= 2'b00;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    ss_control <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_sequencer.sv
// Directed bench for store_sequencer: one instance at MEM_LATENCY=1 and one at MEM_LATENCY=3.
module tb_store_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1, start3;
    logic [1:0]  st;
    logic [31:0] addr;

    logic [31:0] ma1, ma3;
    logic [1:0]  ss1, ss3;
    logic        rd1, ld1, wr1, busy1, done1, mis1;
    logic        rd3, ld3, wr3, busy3, done3, mis3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    store_sequencer #(.MEM_LATENCY(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .store_type(st), .addr_in(addr),
        .mem_addr(ma1), .mem_rd(rd1), .mdr_load(ld1), .ss_control(ss1),
        .mem_wr(wr1), .busy(busy1), .done(done1), .misalign(mis1)
    );

    store_sequencer #(.MEM_LATENCY(3), .CNT_W(4)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .store_type(st), .addr_in(addr),
        .mem_addr(ma3), .mem_rd(rd3), .mdr_load(ld3), .ss_control(ss3),
        .mem_wr(wr3), .busy(busy3), .done(done3), .misalign(mis3)
    );

    // Flag order: {mem_rd, mdr_load, mem_wr, busy, done, misalign}
    function automatic logic [5:0] flg(input int sel);
        return (sel == 1) ? {rd1, ld1, wr1, busy1, done1, mis1}
                          : {rd3, ld3, wr3, busy3, done3, mis3};
    endfunction

    function automatic logic [31:0] mav(input int sel);
        return (sel == 1) ? ma1 : ma3;
    endfunction

    function automatic logic [1:0] ssv(input int sel);
        return (sel == 1) ? ss1 : ss3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 1) start1 = v;
        else start3 = v;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_fault(input logic [1:0] t, input logic [31:0] a);
`ifdef STORE_SEQ_ALIGN_CHECK_EN
        return ((t == 2'b00) && (a[1:0] != 2'b00)) || ((t == 2'b01) && a[0]);
`else
        return 1'b0;
`endif
    endfunction

    // Expected flags in cycle c (c=1 is the cycle after the accepting edge).
    function automatic logic [5:0] exp_flags(input int lat, input logic [1:0] t,
                                             input logic flt, input int c);
        logic [5:0] f;
        f = 6'b000100;
        if (flt) f = 6'b000111;
        else if (t == 2'b00) begin
            if (c == 1) f[3] = 1'b1;
            if (c == 2) f[1] = 1'b1;
        end else begin
            if (c <= lat) f[5] = 1'b1;
            if (c == lat + 1) f[4] = 1'b1;
            if (c == lat + 2) f[3] = 1'b1;
            if (c == lat + 3) f[1] = 1'b1;
        end
        return f;
    endfunction

    task automatic run_store(input int sel, input logic [1:0] t, input logic [31:0] a);
        int lat, ncyc;
        logic flt;
        lat  = sel;
        flt  = is_fault(t, a);
        ncyc = flt ? 1 : ((t == 2'b00) ? 2 : lat + 3);
        st = t;
        addr = a;
        set_start(sel, 1'b1);
        tick();
        set_start(sel, 1'b0);
        addr = ~a;
        st = ~t;
        for (int c = 1; c <= ncyc; c++) begin
            chk($sformatf("L%0d_t%0d_a%0h_flags_c%0d", lat, t, a, c),
                32'(flg(sel)), 32'(exp_flags(lat, t, flt, c)));
            chk($sformatf("L%0d_t%0d_a%0h_addr_c%0d", lat, t, a, c), mav(sel), a);
            chk($sformatf("L%0d_t%0d_a%0h_ss_c%0d", lat, t, a, c), 32'(ssv(sel)), 32'(t));
            tick();
        end
        chk($sformatf("L%0d_t%0d_a%0h_idle_flags", lat, t, a), 32'(flg(sel)), 32'd0);
        chk($sformatf("L%0d_t%0d_a%0h_idle_ss", lat, t, a), 32'(ssv(sel)), 32'd0);
    endtask

    initial begin
        bit seen;
        reset = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        st = 2'b00;
        addr = 32'hDEAD_BEEF;
        tick();
        tick();
        for (int s = 1; s <= 3; s += 2) begin
            chk($sformatf("reset_flags_L%0d", s), 32'(flg(s)), 32'd0);
            chk($sformatf("reset_addr_L%0d", s), mav(s), 32'd0);
            chk($sformatf("reset_ss_L%0d", s), 32'(ssv(s)), 32'd0);
        end
        reset = 1'b0;
        tick();

        // Main stores at both latencies, back-to-back from the cycle after done
        run_store(1, 2'b00, 32'h0000_0010);
        run_store(1, 2'b01, 32'h0000_0022);
        run_store(3, 2'b01, 32'h0000_0022);
        run_store(1, 2'b10, 32'h0000_0003);
        run_store(1, 2'b11, 32'h0000_0003);
        run_store(3, 2'b10, 32'h0000_0003);
        run_store(3, 2'b11, 32'h0000_0003);

        // start held high with a changing address through an sb on the latency-1 unit
        st = 2'b10;
        addr = 32'h0000_0100;
        start1 = 1'b1;
        tick();
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("hold_flags_c%0d", c), 32'(flg(1)), 32'(exp_flags(1, 2'b10, 1'b0, c)));
            chk($sformatf("hold_addr_c%0d", c), ma1, 32'h0000_0100);
            chk($sformatf("hold_ss_c%0d", c), 32'(ss1), 32'd2);
            addr = 32'h0000_0100 + 32'(c * 16);
            tick();
        end
        chk("hold_idle_after_done", 32'(flg(1)), 32'd0);
        addr = 32'h0000_0200;
        tick();
        chk("hold_next_accept_flags", 32'(flg(1)), 32'(exp_flags(1, 2'b10, 1'b0, 1)));
        chk("hold_next_accept_addr", ma1, 32'h0000_0200);
        start1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (done1) seen = 1'b1;
        end
        chk("hold_drain_done", 32'(seen), 32'd1);
        tick();
        chk("hold_drain_idle", 32'(flg(1)), 32'd0);

        // Reset in the middle of a READ on the latency-3 unit
        st = 2'b01;
        addr = 32'h0000_0022;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        chk("rst_mid_read_c1", 32'(flg(3)), 32'(exp_flags(3, 2'b01, 1'b0, 1)));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_flags", 32'(flg(3)), 32'd0);
        chk("rst_mid_addr", ma3, 32'd0);
        chk("rst_mid_ss", 32'(ss3), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rst_mid_no_activity_%0d", i), 32'(flg(3)), 32'd0);
        end
        run_store(3, 2'b00, 32'h0000_0040);

        // Misaligned addresses: faults with the alignment check, normal stores without it
        run_store(1, 2'b00, 32'h0000_0002);
        run_store(1, 2'b01, 32'h0000_0001);
        run_store(1, 2'b10, 32'h0000_0001);
        run_store(3, 2'b00, 32'h0000_0002);
        run_store(3, 2'b11, 32'h0000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_sequencer.md
Name: store_sequencer

Overview:
Multi-cycle controller that sequences sw/sh/sb stores through the store-merge datapath and memory. Word stores go straight to a write cycle. Sub-word stores run a read-modify-write: read the target word, load it into MDR, then write the merge of B and MDR. Sits beside the main control FSM, which hands over one store per start pulse and waits for done.

Parameters:
MEM_LATENCY, 1, memory read latency in cycles (≥1); cycles mem_rd is held before read data is valid
CNT_W, 4, width of internal latency counter; must hold MEM_LATENCY

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
store_type  input  2  00 sw, 01 sh, 10 sb, 11 treated as sb (bit1 has priority)
addr_in  input  32  byte address of store; sampled with start
mem_addr  output  32  registered address driven to memory
mem_rd  output  1  memory read strobe (sub-word RMW only)
mdr_load  output  1  load MDR with memory read data
ss_control  output  2  select for store-merge datapath, held from start acceptance to DONE
mem_wr  output  1  memory write strobe, exactly one cycle per store
busy  output  1  high from cycle after accepted start through DONE
done  output  1  one-cycle completion pulse
misalign  output  1  alignment fault pulse (see Optional Feature)

Behaviour:
- Clock/reset: single clock clk; reset synchronous, active-high.
- Reset: state=IDLE; mem_addr=0, ss_control=00, counter=0; mem_rd, mdr_load, mem_wr, busy, done, misalign=0. Reset asserted mid-operation aborts on the next edge; no mem_wr may follow a reset edge.
- All outputs are registered or decoded from registered state only; no combinational path from start to any output.
- States: IDLE, READ, LATCH, WRITE, DONE.
- IDLE: on start=1, latch addr_in→mem_addr and store_type→ss_control. For 00 go to WRITE; otherwise counter=MEM_LATENCY−1 and go to READ. start=0: stay.
- READ: mem_rd=1, busy=1. Counter≠0: decrement and stay. Counter=0: go to LATCH.
- LATCH: mdr_load=1 for one cycle; go to WRITE.
- WRITE: mem_wr=1 for one cycle; go to DONE.
- DONE: done=1 for one cycle; return to IDLE. ss_control returns to 00 on entering IDLE.
- Latency, with start accepted at edge 0:
  - sw: WRITE is cycle 1, DONE is cycle 2.
  - sh/sb: READ is cycles 1..MEM_LATENCY, LATCH is MEM_LATENCY+1, WRITE is MEM_LATENCY+2, DONE is MEM_LATENCY+3.
- start asserted while not in IDLE (including the DONE cycle) is ignored, not queued. Back-to-back stores are possible from the cycle after DONE.
- mem_addr and ss_control stay stable for the whole operation, regardless of addr_in/store_type changes.
- mem_rd, mdr_load and mem_wr are mutually exclusive in every cycle.
- Address bits [1:0] are passed unchanged; the memory is word-addressed via mem_addr[31:2].

Optional Feature:
Macro STORE_SEQ_ALIGN_CHECK_EN.
- Defined: in IDLE on start, a fault is sh with addr_in[0]=1, or sw with addr_in[1:0]≠00. On a fault:
  - no READ/LATCH/WRITE;
  - next cycle is DONE with done=1 and misalign=1 (both one-cycle);
  - mem_wr never asserts.
- sb never faults.
- Not defined: misalign tied 0; all addresses are processed normally.

Test Plan:
- Reset, then sw with addr_in=0x00000010 → mem_wr=1 with mem_addr=0x10 and ss_control=00 in cycle 1; done in cycle 2; mem_rd and mdr_load never high.
- sh at 0x00000022, MEM_LATENCY=1 → mem_rd cycle 1, mdr_load cycle 2, mem_wr cycle 3, done cycle 4; ss_control=01 throughout. Repeat with MEM_LATENCY=3: mem_rd cycles 1–3, done cycle 6.
- sb (10) and type 11 at 0x00000003 → identical timing; ss_control=10 and 11 held; exactly one mem_wr each.
- Hold start=1 continuously and toggle addr_in every cycle during an sb → only the first address used; next store accepted the cycle after done; no start captured during DONE.
- Assert reset during READ of an sh → next cycle all outputs 0, state IDLE, no mem_wr; a new sw then completes normally.
- With STORE_SEQ_ALIGN_CHECK_EN: sw at 0x00000002 and sh at 0x00000001 → done=misalign=1 in cycle 1, mem_wr=0. sb at 0x00000001 → normal RMW with misalign=0. Without the macro, sw at 0x00000002 writes in cycle 1.
